// File: rtl/mux_serializer_if.sv
// mux_serializer_if: parallel-word handshake in, paced serial bit stream out
interface mux_serializer_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(WIDTH)
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             shift_en;
    logic [SEL_W-1:0] sel;
    logic             sout;
    logic             sout_valid;
    logic             sof;
    logic             eof;
    logic             busy;

    modport master (
        output din, din_valid, shift_en,
        input  din_ready, sel, sout, sout_valid, sof, eof, busy
    );

    modport slave (
        input  din, din_valid, shift_en,
        output din_ready, sel, sout, sout_valid, sof, eof, busy
    );
endinterface

// File: rtl/mux_serializer.sv
// mux_serializer: captures a parallel word and streams it one bit per enabled
// clock with a visible select index and sof/eof frame markers.
// Optional even-parity trailer bit when MUX_SERIALIZER_PARITY_EN is defined.
module mux_serializer #(
    parameter int WIDTH     = 8,
    parameter int SEL_W     = $clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b0
) (
    input logic             clk,
    input logic             rst_n,
    mux_serializer_if.slave bus
);
    localparam logic [SEL_W-1:0] START = MSB_FIRST ? SEL_W'(WIDTH - 1) : '0;
    localparam logic [SEL_W-1:0] LAST  = MSB_FIRST ? '0 : SEL_W'(WIDTH - 1);

`ifdef MUX_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             vld_q, vld_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             at_end;
    logic             ready;
    logic             xfer;
    logic             sout_c;

    // Next-state, capture and select stepping; flags derived from the next position
    always_comb begin
        at_end  = sel_q == LAST;
`ifdef MUX_SERIALIZER_PARITY_EN
        ready   = state_q == IDLE || (state_q == PARITY && bus.shift_en);
`else
        ready   = state_q == IDLE || (state_q == SHIFT && at_end && bus.shift_en);
`endif
        xfer    = bus.din_valid && ready;
        state_d = state_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        if (xfer) begin
            state_d = SHIFT;
            hold_d  = bus.din;
            sel_d   = START;
        end else if (bus.shift_en && state_q == SHIFT) begin
            if (!at_end)
                sel_d = MSB_FIRST ? sel_q - SEL_W'(1) : sel_q + SEL_W'(1);
            else
`ifdef MUX_SERIALIZER_PARITY_EN
                state_d = PARITY;
`else
                state_d = IDLE;
`endif
        end
`ifdef MUX_SERIALIZER_PARITY_EN
        else if (bus.shift_en && state_q == PARITY) begin
            state_d = IDLE;
        end
`endif
        vld_d = state_d != IDLE;
        sof_d = state_d == SHIFT && sel_d == START;
`ifdef MUX_SERIALIZER_PARITY_EN
        eof_d = state_d == PARITY;
`else
        eof_d = state_d == SHIFT && sel_d == LAST;
`endif
    end

    // State, data hold and registered frame flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            sel_q   <= '0;
            vld_q   <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            vld_q   <= vld_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
        end
    end

    // Serial bit is a pure mux of the held word; the trailer carries even parity
    always_comb begin
`ifdef MUX_SERIALIZER_PARITY_EN
        sout_c = state_q == PARITY ? ^hold_q : hold_q[sel_q];
`else
        sout_c = hold_q[sel_q];
`endif
    end

    assign bus.din_ready  = ready;
    assign bus.sel        = sel_q;
    assign bus.sout       = sout_c;
    assign bus.sout_valid = vld_q;
    assign bus.sof        = sof_q;
    assign bus.eof        = eof_q;
    assign bus.busy       = vld_q;
endmodule

// File: tb/tb_mux_serializer.sv
// tb_mux_serializer: LSB-first and MSB-first instances driven in lockstep,
// checked against a fixed vector table, directed sequences and a frame-queue model.
module tb_mux_serializer;
    localparam int W  = 8;
    localparam int SW = 3;
`ifdef MUX_SERIALIZER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FL = W + int'(PAR);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din;
    logic         din_valid;
    logic         shift_en;
    int           vecs = 0;
    int           errs = 0;

    always #5 clk = ~clk;

    mux_serializer_if #(.WIDTH(W)) b0 ();
    mux_serializer_if #(.WIDTH(W)) b1 ();

    assign b0.din = din;
    assign b0.din_valid = din_valid;
    assign b0.shift_en = shift_en;
    assign b1.din = din;
    assign b1.din_valid = din_valid;
    assign b1.shift_en = shift_en;

    mux_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    mux_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    // Reference model: one queue entry per serial position still to be sent
    typedef struct {
        logic [SW-1:0] sel;
        logic          b;
        logic          sof;
        logic          eof;
    } ent_t;
    ent_t q0[$];
    ent_t q1[$];

    typedef struct {
        logic          v;
        logic [W-1:0]  d;
        logic          e;
        logic          ov;
        logic          rdy;
        logic          sof;
        logic          eof;
        logic [SW-1:0] s0;
        logic          o0;
        logic [SW-1:0] s1;
        logic          o1;
    } vec_t;
    vec_t tab[$];

    function automatic vec_t mk(logic v, logic [W-1:0] d, logic e, logic ov, logic rdy,
                                logic sf, logic ef, int s0, logic o0, int s1, logic o1);
        vec_t t;
        t.v = v; t.d = d; t.e = e; t.ov = ov; t.rdy = rdy; t.sof = sf; t.eof = ef;
        t.s0 = SW'(s0); t.o0 = o0; t.s1 = SW'(s1); t.o1 = o1;
        return t;
    endfunction

    function automatic void push_frame(int m, logic [W-1:0] w);
        ent_t e;
        for (int k = 0; k < W; k++) begin
            e.sel = SW'(m == 1 ? W - 1 - k : k);
            e.b   = w[e.sel];
            e.sof = k == 0;
            e.eof = k == W - 1 && !PAR;
            if (m == 1) q1.push_back(e); else q0.push_back(e);
        end
        if (PAR) begin
            e.sel = SW'(m == 1 ? 0 : W - 1);
            e.b   = ^w;
            e.sof = 1'b0;
            e.eof = 1'b1;
            if (m == 1) q1.push_back(e); else q0.push_back(e);
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mchk(input int m);
        int   n;
        ent_t e;
        n = m == 1 ? q1.size() : q0.size();
        if (n > 0) e = m == 1 ? q1[0] : q0[0];
        chk($sformatf("m%0d_vld", m), m == 1 ? b1.sout_valid : b0.sout_valid, n > 0);
        chk($sformatf("m%0d_busy", m), m == 1 ? b1.busy : b0.busy, n > 0);
        chk($sformatf("m%0d_rdy", m), m == 1 ? b1.din_ready : b0.din_ready,
            n == 0 || (n == 1 && shift_en));
        chk($sformatf("m%0d_sof", m), m == 1 ? b1.sof : b0.sof, n > 0 && e.sof);
        chk($sformatf("m%0d_eof", m), m == 1 ? b1.eof : b0.eof, n > 0 && e.eof);
        if (n > 0) begin
            chk($sformatf("m%0d_sel", m), m == 1 ? b1.sel : b0.sel, e.sel);
            chk($sformatf("m%0d_sout", m), m == 1 ? b1.sout : b0.sout, e.b);
        end
    endtask

    task automatic drive(input logic [W-1:0] d, input logic v, input logic e);
        din = d; din_valid = v; shift_en = e;
        #4;
    endtask

    task automatic adv();
        logic r0, r1;
        r0 = q0.size() == 0 || (q0.size() == 1 && shift_en);
        r1 = q1.size() == 0 || (q1.size() == 1 && shift_en);
        @(posedge clk);
        if (q0.size() > 0 && shift_en) void'(q0.pop_front());
        if (q1.size() > 0 && shift_en) void'(q1.pop_front());
        if (din_valid && r0) push_frame(0, din);
        if (din_valid && r1) push_frame(1, din);
        #1;
    endtask

    task automatic run(input logic [W-1:0] d, input logic v, input logic e);
        drive(d, v, e);
        mchk(0);
        mchk(1);
        adv();
    endtask

    task automatic rst_chk(input string n, input logic rdy, input logic v, input logic sf,
                           input logic ef, input logic bz, input logic [SW-1:0] s, input logic o);
        chk({n, "_rdy"}, rdy, 1'b1);
        chk({n, "_vld"}, v, 1'b0);
        chk({n, "_sof"}, sf, 1'b0);
        chk({n, "_eof"}, ef, 1'b0);
        chk({n, "_busy"}, bz, 1'b0);
        chk({n, "_sel"}, s, '0);
        chk({n, "_sout"}, o, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        din_valid = 1'b1;
        #1;
        rst_chk("rst0", b0.din_ready, b0.sout_valid, b0.sof, b0.eof, b0.busy, b0.sel, b0.sout);
        rst_chk("rst1", b1.din_ready, b1.sout_valid, b1.sof, b1.eof, b1.busy, b1.sel, b1.sout);
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        logic o_lsb[W] = '{1, 1, 0, 1, 0, 1, 0, 1};
        logic o_msb[W] = '{1, 0, 1, 0, 1, 0, 1, 1};
        int   nv, nr;
        din = '0; din_valid = 1'b0; shift_en = 1'b0;

        tab.push_back(mk(1, 8'b10101011, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < W; i++)
            tab.push_back(mk(0, 8'h00, 1, 1, i == W - 1 && !PAR, i == 0, i == W - 1 && !PAR,
                             i, o_lsb[i], W - 1 - i, o_msb[i]));
        if (PAR) tab.push_back(mk(0, 8'h00, 1, 1, 1, 0, 1, W - 1, 1, 0, 1));
        tab.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, W - 1, 0, 0, 0));

        @(posedge clk);
        #1;
        do_reset();

        // Plan items 1, 2 and 6: fixed word through both bit orders
        foreach (tab[i]) begin
            drive(tab[i].d, tab[i].v, tab[i].e);
            chk($sformatf("tab%0d_vld0", i), b0.sout_valid, tab[i].ov);
            chk($sformatf("tab%0d_vld1", i), b1.sout_valid, tab[i].ov);
            chk($sformatf("tab%0d_busy0", i), b0.busy, tab[i].ov);
            chk($sformatf("tab%0d_rdy0", i), b0.din_ready, tab[i].rdy);
            chk($sformatf("tab%0d_rdy1", i), b1.din_ready, tab[i].rdy);
            chk($sformatf("tab%0d_sof0", i), b0.sof, tab[i].sof);
            chk($sformatf("tab%0d_eof0", i), b0.eof, tab[i].eof);
            chk($sformatf("tab%0d_sof1", i), b1.sof, tab[i].sof);
            chk($sformatf("tab%0d_eof1", i), b1.eof, tab[i].eof);
            chk($sformatf("tab%0d_sel0", i), b0.sel, tab[i].s0);
            chk($sformatf("tab%0d_sel1", i), b1.sel, tab[i].s1);
            if (tab[i].ov) begin
                chk($sformatf("tab%0d_sout0", i), b0.sout, tab[i].o0);
                chk($sformatf("tab%0d_sout1", i), b1.sout, tab[i].o1);
            end
            adv();
        end

        // Back-to-back frames with din_valid held high
        run(8'hA5, 1, 1);
        nv = 0; nr = 0;
        for (int i = 0; i < 2 * FL; i++) begin
            drive(8'h3C, i < FL, 1);
            nv += int'(b0.sout_valid);
            nr += int'(b0.din_ready);
            mchk(0);
            mchk(1);
            adv();
        end
        chk("b2b_valid_cycles", nv, 2 * FL);
        chk("b2b_ready_pulses", nr, 2);

        // Enable toggling stretches a frame to twice its length
        run(8'hF0, 1, 1);
        nv = 0;
        for (int i = 0; i < 2 * FL + 2; i++) begin
            drive(8'h00, 0, logic'(i % 2));
            nv += int'(b0.sout_valid);
            mchk(0);
            mchk(1);
            adv();
        end
        chk("toggle_frame_cycles", nv, 2 * FL);

        // Reset in the middle of a frame, then a fresh word
        run(8'hC3, 1, 1);
        for (int i = 0; i < 4; i++) run(8'h00, 0, 1);
        chk("mid_sel_before_reset", b0.sel, 4);
        do_reset();
        run(8'h01, 1, 1);
        for (int i = 0; i < FL + 2; i++) run(8'h00, 0, 1);

        // Randomized traffic against the frame-queue model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            else run(W'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
